// File: rtl/round_sequencer.sv
// Round timer sequencer: IDLE -> READY countdown -> RUN -> DONE, with pause.
// Hundredths countdown is compiled in only when ROUND_HUNDREDTHS_EN is defined.
module round_sequencer #(
   parameter int ROUND_TENS = 6,
   parameter int ROUND_ONES = 0,
   parameter int READY_SECS = 3
) (
   input  logic       clk100,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       start_n,
   input  logic       pause_n,
   output logic [3:0] secs_tens,
   output logic [3:0] secs_ones,
   output logic [3:0] hund_tens,
   output logic [3:0] hund_ones,
   output logic [1:0] ready_cnt,
   output logic [2:0] state,
   output logic       round_active,
   output logic       time_up,
   output logic       done_pulse
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READY = 3'd1,
      S_RUN   = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [3:0] INIT_T = 4'(ROUND_TENS);
   localparam logic [3:0] INIT_O = 4'(ROUND_ONES);
   localparam logic [1:0] INIT_R = 2'(READY_SECS);

   state_t     r_state;
   logic [3:0] r_secs_t, r_secs_o;
   logic [1:0] r_ready;
   logic       r_active, r_time_up, r_done;
   logic [1:0] r_start_s, r_pause_s;
   logic       r_start_p, r_pause_p;
   logic [1:0] r_flush;
   logic       w_start, w_pause, w_last;

   // Edge history stays 0 until the synchronizers hold real samples, so a key
   // held low through reset release never looks like a fresh press.
   always_ff @(posedge clk100 or posedge reset) begin
      if (reset) begin
         r_start_s <= 2'b11;
         r_pause_s <= 2'b11;
         r_start_p <= 1'b0;
         r_pause_p <= 1'b0;
         r_flush   <= 2'b00;
      end else begin
         r_start_s <= {r_start_s[0], start_n};
         r_pause_s <= {r_pause_s[0], pause_n};
         r_flush   <= {r_flush[0], 1'b1};
         r_start_p <= r_start_s[1] & r_flush[1];
         r_pause_p <= r_pause_s[1] & r_flush[1];
      end
   end

   assign w_start = r_start_p & ~r_start_s[1];
   assign w_pause = r_pause_p & ~r_pause_s[1];
   assign w_last  = (r_secs_t == 4'd0) && (r_secs_o == 4'd1);

   always_ff @(posedge clk100 or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_secs_t  <= INIT_T;
         r_secs_o  <= INIT_O;
         r_ready   <= 2'd0;
         r_active  <= 1'b0;
         r_time_up <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: if (w_start) begin
               r_state   <= S_READY;
               r_ready   <= INIT_R;
               r_secs_t  <= INIT_T;
               r_secs_o  <= INIT_O;
               r_time_up <= 1'b0;
            end
            S_READY: if (tick_1hz) begin
               if (r_ready == 2'd1) begin
                  r_state  <= S_RUN;
                  r_active <= 1'b1;
               end
               r_ready <= r_ready - 2'd1;
            end
            S_RUN: begin
               // Pause wins over a coincident tick; that tick is dropped.
               if (w_pause) begin
                  r_state <= S_PAUSE;
               end else if (tick_1hz) begin
                  if (w_last) begin
                     r_state   <= S_DONE;
                     r_secs_o  <= 4'd0;
                     r_active  <= 1'b0;
                     r_time_up <= 1'b1;
                     r_done    <= 1'b1;
                  end else if (r_secs_o == 4'd0) begin
                     r_secs_o <= 4'd9;
                     r_secs_t <= r_secs_t - 4'd1;
                  end else begin
                     r_secs_o <= r_secs_o - 4'd1;
                  end
               end
            end
            S_PAUSE: if (w_pause) r_state <= S_RUN;
            default: begin
               r_state   <= S_IDLE;
               r_secs_t  <= INIT_T;
               r_secs_o  <= INIT_O;
               r_ready   <= 2'd0;
               r_active  <= 1'b0;
               r_time_up <= 1'b0;
            end
         endcase
      end
   end

`ifdef ROUND_HUNDREDTHS_EN
   logic [3:0] r_hund_t, r_hund_o;

   always_ff @(posedge clk100 or posedge reset) begin
      if (reset) begin
         r_hund_t <= 4'd0;
         r_hund_o <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: if (w_start) begin
               r_hund_t <= 4'd0;
               r_hund_o <= 4'd0;
            end
            S_READY: if (tick_1hz && r_ready == 2'd1) begin
               r_hund_t <= 4'd9;
               r_hund_o <= 4'd9;
            end
            S_RUN: if (!w_pause) begin
               if (tick_1hz) begin
                  r_hund_t <= w_last ? 4'd0 : 4'd9;
                  r_hund_o <= w_last ? 4'd0 : 4'd9;
               end else if (r_hund_o != 4'd0) begin
                  r_hund_o <= r_hund_o - 4'd1;
               end else if (r_hund_t != 4'd0) begin
                  r_hund_o <= 4'd9;
                  r_hund_t <= r_hund_t - 4'd1;
               end
            end
            S_PAUSE: ;
            default: begin
               r_hund_t <= 4'd0;
               r_hund_o <= 4'd0;
            end
         endcase
      end
   end

   assign hund_tens = r_hund_t;
   assign hund_ones = r_hund_o;
`else
   assign hund_tens = 4'd0;
   assign hund_ones = 4'd0;
`endif

   assign secs_tens    = r_secs_t;
   assign secs_ones    = r_secs_o;
   assign ready_cnt    = r_ready;
   assign state        = r_state;
   assign round_active = r_active;
   assign time_up      = r_time_up;
   assign done_pulse   = r_done;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: decimal-arithmetic model checked every cycle,
// plus directed literal checks along a scripted round.
module tb_round_sequencer;
   localparam int RT = 6, RO = 0, RS = 3;
`ifdef ROUND_HUNDREDTHS_EN
   localparam bit HEN = 1'b1;
`else
   localparam bit HEN = 1'b0;
`endif

   logic       clk100 = 1'b0, reset, tick_1hz, start_n, pause_n;
   logic [3:0] secs_tens, secs_ones, hund_tens, hund_ones;
   logic [1:0] ready_cnt;
   logic [2:0] state;
   logic       round_active, time_up, done_pulse;

   int nchk = 0, nfail = 0;

   round_sequencer #(.ROUND_TENS(RT), .ROUND_ONES(RO), .READY_SECS(RS)) dut (
      .clk100(clk100), .reset(reset), .tick_1hz(tick_1hz), .start_n(start_n),
      .pause_n(pause_n), .secs_tens(secs_tens), .secs_ones(secs_ones),
      .hund_tens(hund_tens), .hund_ones(hund_ones), .ready_cnt(ready_cnt),
      .state(state), .round_active(round_active), .time_up(time_up),
      .done_pulse(done_pulse));

   always #5 clk100 = ~clk100;

   // Model: plain decimal counters; a press acts on the edge where the key was
   // sampled high three edges back and low two edges back.
   int m_st, m_secs, m_hund, m_rdy, n;
   bit m_done, sp, pp;
   bit hs[3], hp[3];

   always @(posedge clk100 or posedge reset) begin
      if (reset) begin
         m_st = 0; m_secs = RT*10 + RO; m_hund = 0; m_rdy = 0; m_done = 0; n = 0;
         hs = '{1'b1, 1'b1, 1'b1}; hp = '{1'b1, 1'b1, 1'b1};
      end else begin
         n++;
         sp = (n >= 4) && hs[2] && !hs[1];
         pp = (n >= 4) && hp[2] && !hp[1];
         hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = start_n;
         hp[2] = hp[1]; hp[1] = hp[0]; hp[0] = pause_n;
         m_done = 0;
         case (m_st)
            0, 4: if (sp) begin m_st = 1; m_rdy = RS; m_secs = RT*10 + RO; m_hund = 0; end
            1: if (tick_1hz) begin
               if (m_rdy == 1) begin m_st = 2; m_rdy = 0; m_hund = 99; end
               else m_rdy--;
            end
            2: if (pp) m_st = 3;
               else if (tick_1hz) begin
                  if (m_secs == 1) begin m_st = 4; m_secs = 0; m_hund = 0; m_done = 1; end
                  else begin m_secs--; m_hund = 99; end
               end else if (m_hund > 0) m_hund--;
            3: if (pp) m_st = 2;
            default: ;
         endcase
      end
   end

   logic [23:0] act, expv;
   always @(negedge clk100) begin
      act  = {state, secs_tens, secs_ones, hund_tens, hund_ones, ready_cnt,
              round_active, time_up, done_pulse};
      expv = {3'(m_st), 4'(m_secs / 10), 4'(m_secs % 10),
              HEN ? 4'(m_hund / 10) : 4'd0, HEN ? 4'(m_hund % 10) : 4'd0,
              2'(m_rdy), m_st == 2 || m_st == 3, m_st == 4, m_done};
      nchk++;
      if (act !== expv) begin
         nfail++;
         $display("FAIL model t=%0t got=%h expected=%h", $time, act, expv);
      end
   end

   task automatic chk(input string nm, input int a, input int e);
      nchk++;
      if (a !== e) begin
         nfail++;
         $display("FAIL %s got=%0d expected=%0d", nm, a, e);
      end
   endtask

   task automatic tick();
      @(negedge clk100) tick_1hz = 1'b1;
      @(negedge clk100) tick_1hz = 1'b0;
   endtask

   task automatic press_start();
      @(negedge clk100) start_n = 1'b0;
      repeat (4) @(negedge clk100);
      start_n = 1'b1;
      repeat (2) @(negedge clk100);
   endtask

   task automatic press_pause();
      @(negedge clk100) pause_n = 1'b0;
      repeat (4) @(negedge clk100);
      pause_n = 1'b1;
      repeat (2) @(negedge clk100);
   endtask

   function automatic int secs();
      return int'(secs_tens) * 10 + int'(secs_ones);
   endfunction

   function automatic int hund();
      return int'(hund_tens) * 10 + int'(hund_ones);
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      tick_1hz = 1'b0; start_n = 1'b1; pause_n = 1'b1; reset = 1'b1;
      repeat (3) @(negedge clk100);
      chk("rst_state", state, 0);
      chk("rst_secs", secs(), 60);
      chk("rst_active", round_active, 0);
      reset = 1'b0;
      repeat (5) @(negedge clk100);

      press_pause();
      chk("pause_in_idle", state, 0);
      press_start();
      chk("ready_state", state, 1);
      chk("ready_cnt3", ready_cnt, 3);
      tick(); chk("ready_cnt2", ready_cnt, 2);
      tick(); chk("ready_cnt1", ready_cnt, 1);
      tick();
      chk("run_state", state, 2);
      chk("run_ready0", ready_cnt, 0);
      chk("run_secs60", secs(), 60);
      chk("run_hund99", hund(), HEN ? 99 : 0);
      press_start();
      chk("start_in_run", state, 2);

      tick(); chk("secs59", secs(), 59);
      repeat (5) @(negedge clk100);
      chk("hund94", hund(), HEN ? 94 : 0);
      repeat (10) tick();
      chk("secs49", secs(), 49);
      repeat (7) tick();
      chk("secs42", secs(), 42);

      // Pause press lands on the same edge as a tick.
      @(negedge clk100) pause_n = 1'b0;
      @(negedge clk100);
      @(negedge clk100) tick_1hz = 1'b1;
      @(negedge clk100) tick_1hz = 1'b0;
      chk("pause_state", state, 3);
      chk("pause_secs42", secs(), 42);
      repeat (2) @(negedge clk100);
      pause_n = 1'b1;
      repeat (2) @(negedge clk100);
      repeat (5) tick();
      chk("pause_hold_secs", secs(), 42);
      chk("pause_hold_state", state, 3);
      press_pause();
      chk("resume_state", state, 2);

      repeat (25) tick();
      chk("secs17", secs(), 17);
      #1 reset = 1'b1;
      #1;
      chk("abort_state", state, 0);
      chk("abort_secs", secs(), 60);
      chk("abort_active", round_active, 0);
      chk("abort_done", done_pulse, 0);

      // Start key held low across reset release must not count as a press.
      @(negedge clk100) start_n = 1'b0;
      @(negedge clk100) reset = 1'b0;
      repeat (8) @(negedge clk100);
      chk("held_key_idle", state, 0);
      start_n = 1'b1;
      repeat (3) @(negedge clk100);
      press_start();
      chk("restart_ready", state, 1);
      repeat (3) tick();
      chk("restart_run", state, 2);
      repeat (59) tick();
      chk("secs01", secs(), 1);
      tick();
      chk("done_state", state, 4);
      chk("done_secs", secs(), 0);
      chk("done_hund", hund(), 0);
      chk("done_time_up", time_up, 1);
      chk("done_pulse_hi", done_pulse, 1);
      @(negedge clk100);
      chk("done_pulse_lo", done_pulse, 0);
      chk("done_time_up_hold", time_up, 1);
      tick();
      chk("tick_in_done", secs(), 0);
      press_pause();
      chk("pause_in_done", state, 4);
      press_start();
      chk("done_to_ready", state, 1);
      chk("done_to_ready_secs", secs(), 60);
      chk("done_to_ready_tu", time_up, 0);

      repeat (2) @(negedge clk100);
      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end
endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameter ROUND_TENS, default 6, round length tens digit (BCD, 0-9).
REQ-002 Parameter ROUND_ONES, default 0, round length ones digit (BCD, 0-9); ROUND_TENS and ROUND_ONES SHALL NOT both be 0.
REQ-003 Parameter READY_SECS, default 3, get-ready countdown length in seconds (1-3).
REQ-004 clk100  input  1  100 Hz system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 tick_1hz  input  1  one-cycle pulse per second, synchronous to clk100.
REQ-007 start_n  input  1  raw active-low start key.
REQ-008 pause_n  input  1  raw active-low pause key.
REQ-009 secs_tens, secs_ones  output  4 each  BCD seconds remaining.
REQ-010 hund_tens, hund_ones  output  4 each  BCD hundredths remaining.
REQ-011 ready_cnt  output  2  get-ready seconds remaining.
REQ-012 state  output  3  IDLE=0, READY=1, RUN=2, PAUSE=3, DONE=4.
REQ-013 round_active  output  1  high in RUN and PAUSE.
REQ-014 time_up  output  1  high in DONE.
REQ-015 done_pulse  output  1  one-cycle pulse on the RUN->DONE transition.

Function
REQ-016 Each key SHALL pass through a 2-flop synchronizer; a press is a 1->0 edge of the synchronized signal, yielding a one-cycle press pulse 3 cycles after the key falls.
REQ-017 IDLE or DONE + start press -> READY; ready_cnt=READY_SECS, secs=ROUND_TENS:ROUND_ONES, hund=00.
REQ-018 READY + tick: ready_cnt decrements; tick with ready_cnt=1 -> RUN, ready_cnt=0, hund=99.
REQ-019 RUN + tick: secs decrement in BCD (ones 0 -> 9 with tens-1); hund reload to 99.
REQ-020 RUN + tick with secs=01 -> DONE same edge, secs=00, hund=00, done_pulse high for that one cycle.
REQ-021 RUN, no tick: hund decrements by 1 in BCD each cycle, saturating at 00.
REQ-022 RUN + pause press -> PAUSE; PAUSE + pause press -> RUN; all counters hold in PAUSE.
REQ-023 Pause press and tick in same RUN cycle: transition to PAUSE taken, tick discarded, no decrement.
REQ-024 Ticks in IDLE, PAUSE, DONE ignored; start press ignored in READY, RUN, PAUSE; pause press ignored outside RUN and PAUSE.
REQ-025 DONE holds secs=00, hund=00 until start press.
REQ-026 Encodings 5-7 of state unreachable; if entered, next edge SHALL go to IDLE with reset values.

Reset
REQ-027 While reset is high: state=IDLE, secs=ROUND_TENS:ROUND_ONES, hund=00, ready_cnt=0, round_active=0, time_up=0, done_pulse=0, synchronizers=1 (no press).
REQ-028 Reset asserted mid-round SHALL abort immediately to the reset values; no done_pulse generated.
REQ-029 A key held low through reset release SHALL NOT produce a press until released and pressed again.

Configuration
REQ-030 Macro ROUND_HUNDREDTHS_EN: when defined, REQ-018/019/021 hundredths behaviour is compiled in.
REQ-031 Without ROUND_HUNDREDTHS_EN, hund_tens and hund_ones SHALL be constant 0 and no hundredths registers synthesized; all other behaviour unchanged.

Verification
REQ-032 Reset, start press, 3 ticks -> state 0->1->2; ready_cnt 3,2,1,0; secs=60 on RUN entry, hund=99 (macro on).
REQ-033 In RUN at secs=60, one tick -> secs=59; 10 further ticks -> 49; with macro, 5 cycles after a tick hund=94.
REQ-034 Run to secs=01, tick -> secs=00, state=4, time_up=1, done_pulse high exactly one cycle.
REQ-035 At secs=42 in RUN, pause press coincident with tick -> PAUSE, secs=42; 5 ticks -> secs 42; pause press -> RUN.
REQ-036 Assert reset in RUN at secs=17 -> state=0, secs=60, round_active=0 immediately, no done_pulse.
REQ-037 Macro off: full round -> hund_tens=hund_ones=0 throughout; all other checks identical.
